// File: rtl/scumv_ramp_pkg.sv
// Shared types and widths for the SCUM-V FMCW ramp sequencer.
// Optional chirp counter is enabled by SCUMV_RAMP_CHIRP_COUNT_EN.
package scumv_ramp_pkg;

    localparam int CODE_W  = 8;
    localparam int DWELL_W = 24;
    localparam int IDLE_W  = 32;
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_RAMP,
        ST_GAP
    } ramp_state_t;

    typedef struct packed {
        logic [CODE_W-1:0]  start;
        logic [CODE_W-1:0]  steps;
        logic [DWELL_W-1:0] cycles;
        logic [IDLE_W-1:0]  idle;
    } ramp_cfg_t;

endpackage

// File: rtl/scumv_ramp_sequencer.sv
// FMCW ramp sequencer: stepped frequency code plus chirp/gap strobes.
// Define SCUMV_RAMP_CHIRP_COUNT_EN to add the io_chirpCount output.
module scumv_ramp_sequencer
    import scumv_ramp_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               io_enable,
    input  logic               io_rst,
    input  logic [CODE_W-1:0]  io_frequencyStepStart,
    input  logic [CODE_W-1:0]  io_numFrequencySteps,
    input  logic [DWELL_W-1:0] io_numCyclesPerFrequency,
    input  logic [IDLE_W-1:0]  io_numIdleCycles,
    output logic [CODE_W-1:0]  io_freqCode,
    output logic               io_rampActive,
    output logic               io_gapActive,
    output logic               io_chirpStart
`ifdef SCUMV_RAMP_CHIRP_COUNT_EN
    ,
    output logic [CNT_W-1:0]   io_chirpCount
`endif
);

    ramp_state_t        state;
    ramp_cfg_t          shadow;
    ramp_cfg_t          cfg_in;
    logic [CODE_W-1:0]  step_idx;
    logic [DWELL_W-1:0] dwell;
    logic [IDLE_W-1:0]  idle_cnt;

    logic [CODE_W-1:0]  steps_m1;
    logic [DWELL_W-1:0] dwell_m1;
    logic [IDLE_W-1:0]  idle_m1;
    logic               clr;
    logic               step_done;
    logic               chirp_done;
    logic               gap_done;
    logic               start_next;

    always_comb begin
        cfg_in.start  = io_frequencyStepStart;
        cfg_in.steps  = io_numFrequencySteps;
        cfg_in.cycles = io_numCyclesPerFrequency;
        cfg_in.idle   = io_numIdleCycles;
    end

    // Zero step/dwell counts behave as one; limits are N-1 so no extra bit.
    always_comb begin
        steps_m1 = '0;
        dwell_m1 = '0;
        if (shadow.steps != '0)
            steps_m1 = shadow.steps - 1'b1;
        if (shadow.cycles != '0)
            dwell_m1 = shadow.cycles - 1'b1;
        idle_m1 = shadow.idle - 1'b1;
    end

    assign clr        = !reset || io_rst;
    assign step_done  = (dwell == dwell_m1);
    assign chirp_done = step_done && (step_idx == steps_m1);
    assign gap_done   = (idle_cnt == idle_m1);

    // A new chirp begins on the cycle after any latch point.
    always_comb begin
        start_next = 1'b0;
        if (!clr && io_enable) begin
            unique case (state)
                ST_OFF:  start_next = 1'b1;
                ST_RAMP: start_next = chirp_done
                                      && (shadow.idle == '0);
                ST_GAP:  start_next = gap_done;
                default: start_next = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (clr || !io_enable) begin
            state         <= ST_OFF;
            io_freqCode   <= '0;
            io_rampActive <= 1'b0;
            io_gapActive  <= 1'b0;
            io_chirpStart <= 1'b0;
            step_idx      <= '0;
            dwell         <= '0;
            idle_cnt      <= '0;
            if (clr)
                shadow <= '0;
        end else begin
            io_chirpStart <= start_next;
            if (start_next) begin
                shadow        <= cfg_in;
                state         <= ST_RAMP;
                io_freqCode   <= cfg_in.start;
                io_rampActive <= 1'b1;
                io_gapActive  <= 1'b0;
                step_idx      <= '0;
                dwell         <= '0;
                idle_cnt      <= '0;
            end else begin
                unique case (state)
                    ST_RAMP: begin
                        if (step_done) begin
                            dwell <= '0;
                            if (chirp_done) begin
                                state         <= ST_GAP;
                                io_freqCode   <= shadow.start;
                                io_rampActive <= 1'b0;
                                io_gapActive  <= 1'b1;
                                idle_cnt      <= '0;
                            end else begin
                                step_idx    <= step_idx + 1'b1;
                                io_freqCode <= io_freqCode + 1'b1;
                            end
                        end else begin
                            dwell <= dwell + 1'b1;
                        end
                    end
                    ST_GAP: begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef SCUMV_RAMP_CHIRP_COUNT_EN
    // First chirp after OFF loads 1: the counter clears and counts it at once.
    always_ff @(posedge clock) begin
        if (clr) begin
            io_chirpCount <= '0;
        end else if (start_next) begin
            if (state == ST_OFF)
                io_chirpCount <= CNT_W'(1);
            else
                io_chirpCount <= io_chirpCount + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_scumv_ramp_sequencer.sv
// Self-checking bench: vector table, directed corners, random vs model.
// Chirp-counter checks run when SCUMV_RAMP_CHIRP_COUNT_EN is defined.
module tb_scumv_ramp_sequencer;
    import scumv_ramp_pkg::*;

    logic               clock = 1'b0;
    logic               reset;
    logic               io_enable;
    logic               io_rst;
    logic [CODE_W-1:0]  io_frequencyStepStart;
    logic [CODE_W-1:0]  io_numFrequencySteps;
    logic [DWELL_W-1:0] io_numCyclesPerFrequency;
    logic [IDLE_W-1:0]  io_numIdleCycles;
    logic [CODE_W-1:0]  io_freqCode;
    logic               io_rampActive;
    logic               io_gapActive;
    logic               io_chirpStart;
`ifdef SCUMV_RAMP_CHIRP_COUNT_EN
    logic [CNT_W-1:0]   io_chirpCount;
`endif

    scumv_ramp_sequencer dut (
        .clock                    (clock),
        .reset                    (reset),
        .io_enable                (io_enable),
        .io_rst                   (io_rst),
        .io_frequencyStepStart    (io_frequencyStepStart),
        .io_numFrequencySteps     (io_numFrequencySteps),
        .io_numCyclesPerFrequency (io_numCyclesPerFrequency),
        .io_numIdleCycles         (io_numIdleCycles),
        .io_freqCode              (io_freqCode),
        .io_rampActive            (io_rampActive),
        .io_gapActive             (io_gapActive),
        .io_chirpStart            (io_chirpStart)
`ifdef SCUMV_RAMP_CHIRP_COUNT_EN
        ,
        .io_chirpCount            (io_chirpCount)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: position t within the current chirp period S*C+I.
    bit     m_on;
    longint m_t;
    longint m_s;
    longint m_c;
    longint m_i;
    longint m_start;
    longint m_cnt;

    function automatic void model_latch();
        m_start = longint'(io_frequencyStepStart);
        m_s = (io_numFrequencySteps == 0) ? 1 : longint'(io_numFrequencySteps);
        m_c = (io_numCyclesPerFrequency == 0) ? 1
              : longint'(io_numCyclesPerFrequency);
        m_i = longint'(io_numIdleCycles);
    endfunction

    function automatic void model_edge();
        if (!reset || io_rst) begin
            m_on  = 1'b0;
            m_cnt = 0;
        end else if (!io_enable) begin
            m_on = 1'b0;
        end else if (!m_on) begin
            m_on  = 1'b1;
            m_t   = 0;
            m_cnt = 1;
            model_latch();
        end else begin
            m_t++;
            if (m_t == m_s * m_c + m_i) begin
                m_t   = 0;
                m_cnt = (m_cnt + 1) % 65536;
                model_latch();
            end
        end
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic check_model();
        longint e_code;
        bit e_ramp, e_gap, e_cs;
        e_code = 0;
        e_ramp = 0;
        e_gap  = 0;
        e_cs   = 0;
        if (m_on) begin
            if (m_t < m_s * m_c) begin
                e_code = (m_start + m_t / m_c) % 256;
                e_ramp = 1;
                e_cs   = (m_t == 0);
            end else begin
                e_code = m_start;
                e_gap  = 1;
            end
        end
        check("model_code", 64'(io_freqCode), 64'(e_code));
        check("model_ramp", 64'(io_rampActive), 64'(e_ramp));
        check("model_gap", 64'(io_gapActive), 64'(e_gap));
        check("model_cs", 64'(io_chirpStart), 64'(e_cs));
`ifdef SCUMV_RAMP_CHIRP_COUNT_EN
        check("model_cnt", 64'(io_chirpCount), 64'(m_cnt));
`endif
    endtask

    task automatic set_cfg(input logic [7:0] st, input logic [7:0] sp,
                           input logic [23:0] cy, input logic [31:0] id);
        io_frequencyStepStart    = st;
        io_numFrequencySteps     = sp;
        io_numCyclesPerFrequency = cy;
        io_numIdleCycles         = id;
    endtask

    typedef struct {
        bit          rst;
        bit          en;
        logic [7:0]  st;
        logic [7:0]  sp;
        logic [23:0] cy;
        logic [31:0] id;
        logic [7:0]  code;
        bit          ramp;
        bit          gap;
        bit          cs;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // Base chirp 10/3/2/4, then abort, wrap, 1x1 back-to-back, io_rst.
        tbl.push_back('{0, 1, 10, 3, 2, 4, 10, 1, 0, 1});
        tbl.push_back('{0, 1, 10, 3, 2, 4, 10, 1, 0, 0});
        tbl.push_back('{0, 1, 10, 3, 2, 4, 11, 1, 0, 0});
        tbl.push_back('{0, 1, 10, 3, 2, 4, 11, 1, 0, 0});
        tbl.push_back('{0, 1, 10, 3, 2, 4, 12, 1, 0, 0});
        tbl.push_back('{0, 1, 10, 3, 2, 4, 12, 1, 0, 0});
        tbl.push_back('{0, 1, 10, 3, 2, 4, 10, 0, 1, 0});
        tbl.push_back('{0, 1, 10, 3, 2, 4, 10, 0, 1, 0});
        tbl.push_back('{0, 1, 10, 3, 2, 4, 10, 0, 1, 0});
        tbl.push_back('{0, 1, 10, 3, 2, 4, 10, 0, 1, 0});
        tbl.push_back('{0, 1, 10, 3, 2, 4, 10, 1, 0, 1});
        tbl.push_back('{0, 1, 10, 3, 2, 4, 10, 1, 0, 0});
        tbl.push_back('{0, 0, 10, 3, 2, 4, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 254, 4, 1, 0, 254, 1, 0, 1});
        tbl.push_back('{0, 1, 254, 4, 1, 0, 255, 1, 0, 0});
        tbl.push_back('{0, 1, 254, 4, 1, 0, 0, 1, 0, 0});
        tbl.push_back('{0, 1, 254, 4, 1, 0, 1, 1, 0, 0});
        tbl.push_back('{0, 1, 254, 4, 1, 0, 254, 1, 0, 1});
        tbl.push_back('{0, 1, 7, 0, 0, 0, 255, 1, 0, 0});
        tbl.push_back('{0, 1, 7, 0, 0, 0, 0, 1, 0, 0});
        tbl.push_back('{0, 1, 7, 0, 0, 0, 1, 1, 0, 0});
        tbl.push_back('{0, 1, 7, 0, 0, 0, 7, 1, 0, 1});
        tbl.push_back('{0, 1, 7, 0, 0, 0, 7, 1, 0, 1});
        tbl.push_back('{0, 1, 7, 0, 0, 0, 7, 1, 0, 1});
        tbl.push_back('{1, 1, 5, 2, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 5, 2, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 5, 2, 1, 0, 5, 1, 0, 1});
        tbl.push_back('{0, 1, 5, 2, 1, 0, 6, 1, 0, 0});
        tbl.push_back('{0, 1, 5, 2, 1, 0, 5, 1, 0, 1});
        tbl.push_back('{0, 1, 5, 2, 1, 0, 6, 1, 0, 0});

        reset     = 1'b0;
        io_enable = 1'b1;
        io_rst    = 1'b0;
        set_cfg(8'd1, 8'd1, 24'd1, 32'd0);
        m_on  = 1'b0;
        m_cnt = 0;
        m_t   = 0;
        repeat (3) tick();
        check("reset_code", 64'(io_freqCode), 64'd0);
        check("reset_ramp", 64'(io_rampActive), 64'd0);
        check("reset_gap", 64'(io_gapActive), 64'd0);
        check("reset_cs", 64'(io_chirpStart), 64'd0);
        reset     = 1'b1;
        io_enable = 1'b0;
        tick();
        check_model();

        foreach (tbl[i]) begin
            io_rst    = tbl[i].rst;
            io_enable = tbl[i].en;
            set_cfg(tbl[i].st, tbl[i].sp, tbl[i].cy, tbl[i].id);
            tick();
            check($sformatf("vec%0d_code", i), 64'(io_freqCode),
                  64'(tbl[i].code));
            check($sformatf("vec%0d_ramp", i), 64'(io_rampActive),
                  64'(tbl[i].ramp));
            check($sformatf("vec%0d_gap", i), 64'(io_gapActive),
                  64'(tbl[i].gap));
            check($sformatf("vec%0d_cs", i), 64'(io_chirpStart),
                  64'(tbl[i].cs));
        end

        // Start rewritten mid-chirp only takes effect at the next latch.
        io_enable = 1'b0;
        tick();
        io_enable = 1'b1;
        set_cfg(8'd10, 8'd3, 24'd2, 32'd2);
        tick();
        check("rewrite_first_cs", 64'(io_chirpStart), 64'd1);
        io_frequencyStepStart = 8'd50;
        repeat (5) begin
            tick();
            check_model();
        end
        tick();
        check("rewrite_gap_code", 64'(io_freqCode), 64'd10);
        check("rewrite_gap", 64'(io_gapActive), 64'd1);
        tick();
        tick();
        check("rewrite_next_code", 64'(io_freqCode), 64'd50);
        check("rewrite_next_cs", 64'(io_chirpStart), 64'd1);

        // Maximum idle count: gap must persist, no early wrap.
        io_enable = 1'b0;
        tick();
        io_enable = 1'b1;
        set_cfg(8'd3, 8'd1, 24'd1, 32'hFFFF_FFFF);
        tick();
        repeat (200) begin
            tick();
            check_model();
        end
        check("maxidle_gap", 64'(io_gapActive), 64'd1);
        io_enable = 1'b0;
        tick();
        check("abort_code", 64'(io_freqCode), 64'd0);
        check("abort_gap", 64'(io_gapActive), 64'd0);

        // Random config churn, enable drops and resets against the model.
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 199) != 0);
            io_rst    = ($urandom_range(0, 99) == 0);
            io_enable = ($urandom_range(0, 39) != 0);
            set_cfg(8'($urandom), 8'($urandom_range(0, 5)),
                    24'($urandom_range(0, 3)), 32'($urandom_range(0, 4)));
            tick();
            check_model();
        end

`ifdef SCUMV_RAMP_CHIRP_COUNT_EN
        reset     = 1'b1;
        io_rst    = 1'b1;
        io_enable = 1'b1;
        set_cfg(8'd9, 8'd0, 24'd0, 32'd0);
        tick();
        check("cnt_rst", 64'(io_chirpCount), 64'd0);
        io_rst = 1'b0;
        repeat (3) tick();
        check("cnt_three", 64'(io_chirpCount), 64'd3);
        io_rst = 1'b1;
        tick();
        check("cnt_clear", 64'(io_chirpCount), 64'd0);
        io_rst = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            tick();
            if (i == 65534)
                check("cnt_max", 64'(io_chirpCount), 64'd65535);
            if ((i % 1024) == 0)
                check_model();
        end
        check("cnt_wrap", 64'(io_chirpCount), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
